// File: rtl/neo_pkg.sv
// Shared definitions for the NEO-B1 linebuffer controller slice.
package neo_pkg;

   // Linebuffer index map used by the WE and CK strobe vectors
   localparam int unsigned BL = 0;
   localparam int unsigned BR = 1;
   localparam int unsigned TL = 2;
   localparam int unsigned TR = 3;

   // Pixel pairs in one 16-pixel sprite strip
   localparam int unsigned STRIP_PAIRS = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WRITE,
      ST_DONE
   } lb_state_t;

endpackage

// File: rtl/neo_lb_wseq.sv
// Render-side strip write sequencer: accepts a strip, loads the render-pair
// address, then steps through the 8 pixel pairs issuing WE and trailing CK.
module neo_lb_wseq (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        CLK_EN_6M,
   input  logic        LINE_START,
   input  logic        TMS0,
   input  logic        SPR_REQ,
   input  logic [8:0]  SPR_X,
   input  logic [15:0] SPR_OPQ,
   input  logic        SPR_FLIP,
   output logic        SPR_ACK,
   output logic        ABORT,
   output logic        BUSY,
   output logic [2:0]  PAIR_IDX,
   output logic        SWAP,
   output logic [15:0] LD_ADDR,
   output logic [1:0]  LD_REND,
   output logic [3:0]  WE,
   output logic [3:0]  CK_REND
);
   import neo_pkg::*;

   lb_state_t   state;
   logic [2:0]  k;
   logic [8:0]  x_q;
   logic [15:0] opq_q;
   logic        flip_q;
   logic        wstep;

   logic [2:0]  idx;
   logic [3:0]  p0;
   logic [3:0]  p1;
   logic [1:0]  buf_l;
   logic [1:0]  buf_r;
   logic [3:0]  rmask;
   logic [3:0]  we_n;

   assign BUSY = (state != ST_IDLE);

   // Pixel selection and render-pair steering for the current write step
   always_comb begin
      idx   = flip_q ? ~k : k;
      p0    = {idx, 1'b0};
      p1    = {idx, 1'b1};
      buf_l = TMS0 ? 2'(BL) : 2'(TL);
      buf_r = TMS0 ? 2'(BR) : 2'(TR);
      rmask = '0;
      rmask[buf_l] = 1'b1;
      rmask[buf_r] = 1'b1;
      we_n  = '0;
      we_n[buf_l] = SWAP ? opq_q[p1] : opq_q[p0];
      we_n[buf_r] = SWAP ? opq_q[p0] : opq_q[p1];
   end

   // Render FSM with registered strobes; LINE_START aborts and drops any pending CK
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state    <= ST_IDLE;
         k        <= '0;
         x_q      <= '0;
         opq_q    <= '0;
         flip_q   <= 1'b0;
         wstep    <= 1'b0;
         SPR_ACK  <= 1'b0;
         ABORT    <= 1'b0;
         PAIR_IDX <= '0;
         SWAP     <= 1'b0;
         LD_ADDR  <= '0;
         LD_REND  <= '0;
         WE       <= '0;
         CK_REND  <= '0;
      end else begin
         LD_REND <= '0;
         WE      <= '0;
         SPR_ACK <= 1'b0;
         ABORT   <= 1'b0;
         LD_ADDR <= '0;
         wstep   <= 1'b0;
         CK_REND <= wstep ? rmask : '0;
         if (CLK_EN_6M) begin
            if (LINE_START) begin
               // the buffer roles flip on this edge, so a trailing CK would hit the display pair
               if (state != ST_IDLE) ABORT <= 1'b1;
               state    <= ST_IDLE;
               SWAP     <= 1'b0;
               PAIR_IDX <= '0;
               CK_REND  <= '0;
            end else begin
               case (state)
                  ST_IDLE: begin
                     if (SPR_REQ) begin
                        x_q    <= SPR_X;
                        opq_q  <= SPR_OPQ;
                        flip_q <= SPR_FLIP;
                        state  <= ST_LOAD;
                     end
                  end
                  ST_LOAD: begin
                     LD_REND <= TMS0 ? 2'b01 : 2'b10;
                     LD_ADDR <= {x_q[8:1], x_q[8:1] + {7'b0, x_q[0]}};
                     SWAP    <= x_q[0];
                     k       <= '0;
                     state   <= ST_WRITE;
                  end
                  ST_WRITE: begin
                     WE       <= we_n;
                     PAIR_IDX <= idx;
                     wstep    <= 1'b1;
                     k        <= k + 3'd1;
                     if (k == 3'(STRIP_PAIRS - 1)) state <= ST_DONE;
                  end
                  ST_DONE: begin
                     SPR_ACK  <= 1'b1;
                     SWAP     <= 1'b0;
                     PAIR_IDX <= '0;
                     state    <= ST_IDLE;
                  end
                  default: state <= ST_IDLE;
               endcase
            end
         end
      end
   end

endmodule

// File: rtl/neo_lb_ctrl.sv
// Linebuffer controller top: buffer flip, display-side strobes and merge of
// the render-side sequencer strobes onto the shared WE/CK/LD outputs.
module neo_lb_ctrl (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        CLK_EN_6M,
   input  logic        LINE_START,
   input  logic        SPR_REQ,
   input  logic [8:0]  SPR_X,
   input  logic [15:0] SPR_OPQ,
   input  logic        SPR_FLIP,
   output logic        SPR_ACK,
   output logic        ABORT,
   output logic        BUSY,
   output logic [2:0]  PAIR_IDX,
   output logic        SWAP,
   output logic [15:0] LD_ADDR,
   output logic        LD1,
   output logic        LD2,
   output logic        SS1,
   output logic        SS2,
   output logic [3:0]  WE,
   output logic [3:0]  CK,
   output logic        TMS0
);
   import neo_pkg::*;

   logic [8:0] hcnt;
   logic [1:0] ld_disp;
   logic [3:0] ck_disp;
   logic [1:0] ld_rend;
   logic [3:0] ck_rend;
   logic [3:0] dmask;

   // Display pair mask: TMS0=0 shows B, TMS0=1 shows T
   always_comb begin
      dmask = '0;
      if (TMS0) begin
         dmask[TL] = 1'b1;
         dmask[TR] = 1'b1;
      end else begin
         dmask[BL] = 1'b1;
         dmask[BR] = 1'b1;
      end
   end

   // Buffer flip, pixel counter and display LD/CK strobes
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         TMS0    <= 1'b0;
         hcnt    <= '0;
         ld_disp <= '0;
         ck_disp <= '0;
      end else begin
         ld_disp <= '0;
         ck_disp <= '0;
         if (CLK_EN_6M) begin
            if (LINE_START) begin
               TMS0    <= ~TMS0;
               hcnt    <= '0;
               // LD goes to the pair that becomes displayed after this flip
               ld_disp <= TMS0 ? 2'b01 : 2'b10;
            end else begin
               hcnt <= hcnt + 9'd1;
               if (hcnt[0]) ck_disp <= dmask;
            end
         end
      end
   end

   neo_lb_wseq u_wseq (
      .CLK        (CLK),
      .nRST       (nRST),
      .CLK_EN_6M  (CLK_EN_6M),
      .LINE_START (LINE_START),
      .TMS0       (TMS0),
      .SPR_REQ    (SPR_REQ),
      .SPR_X      (SPR_X),
      .SPR_OPQ    (SPR_OPQ),
      .SPR_FLIP   (SPR_FLIP),
      .SPR_ACK    (SPR_ACK),
      .ABORT      (ABORT),
      .BUSY       (BUSY),
      .PAIR_IDX   (PAIR_IDX),
      .SWAP       (SWAP),
      .LD_ADDR    (LD_ADDR),
      .LD_REND    (ld_rend),
      .WE         (WE),
      .CK_REND    (ck_rend)
   );

   // Display and render strobes always target opposite pairs, so OR-merging is safe
   assign LD1 = ld_disp[0] | ld_rend[0];
   assign LD2 = ld_disp[1] | ld_rend[1];
   assign CK  = ck_disp | ck_rend;
   assign SS1 = ~TMS0;
   assign SS2 = TMS0;

endmodule

// File: tb/tb_neo_lb_ctrl.sv
// Directed bench for neo_lb_ctrl: one enable every two CLKs, outputs sampled 1ns after each edge.
module tb_neo_lb_ctrl;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        CLK_EN_6M;
   logic        LINE_START;
   logic        SPR_REQ;
   logic [8:0]  SPR_X;
   logic [15:0] SPR_OPQ;
   logic        SPR_FLIP;
   logic        SPR_ACK;
   logic        ABORT;
   logic        BUSY;
   logic [2:0]  PAIR_IDX;
   logic        SWAP;
   logic [15:0] LD_ADDR;
   logic        LD1;
   logic        LD2;
   logic        SS1;
   logic        SS2;
   logic [3:0]  WE;
   logic [3:0]  CK;
   logic        TMS0;

   int checks = 0;
   int errors = 0;
   int we_tl  = 0;
   int we_tr  = 0;

   neo_lb_ctrl dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .CLK_EN_6M  (CLK_EN_6M),
      .LINE_START (LINE_START),
      .SPR_REQ    (SPR_REQ),
      .SPR_X      (SPR_X),
      .SPR_OPQ    (SPR_OPQ),
      .SPR_FLIP   (SPR_FLIP),
      .SPR_ACK    (SPR_ACK),
      .ABORT      (ABORT),
      .BUSY       (BUSY),
      .PAIR_IDX   (PAIR_IDX),
      .SWAP       (SWAP),
      .LD_ADDR    (LD_ADDR),
      .LD1        (LD1),
      .LD2        (LD2),
      .SS1        (SS1),
      .SS2        (SS2),
      .WE         (WE),
      .CK         (CK),
      .TMS0       (TMS0)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one enabled CLK edge; returns 1ns after it with enables dropped
   task automatic en_tick(input logic ls);
      CLK_EN_6M  = 1'b1;
      LINE_START = ls;
      @(posedge CLK);
      #1;
      CLK_EN_6M  = 1'b0;
      LINE_START = 1'b0;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      nRST = 1'b0; CLK_EN_6M = 1'b0; LINE_START = 1'b0;
      SPR_REQ = 1'b0; SPR_X = '0; SPR_OPQ = '0; SPR_FLIP = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_tms0", 32'(TMS0), 0);
      chk("rst_busy", 32'(BUSY), 0);
      chk("rst_we", 32'(WE), 0);
      chk("rst_ck", 32'(CK), 0);
      chk("rst_ld", 32'({LD2, LD1}), 0);
      chk("rst_ldaddr", 32'(LD_ADDR), 0);
      chk("rst_ack_abort", 32'({SPR_ACK, ABORT}), 0);
      chk("rst_swap_pidx", 32'({SWAP, PAIR_IDX}), 0);
      chk("rst_ss", 32'({SS2, SS1}), 32'b01);
      nRST = 1'b1;

      // three line starts plus one more to land on TMS0=0
      en_tick(1'b1);
      chk("ls1_tms0", 32'(TMS0), 1);
      chk("ls1_ld", 32'({LD2, LD1}), 32'b10);
      chk("ls1_ldaddr", 32'(LD_ADDR), 0);
      chk("ls1_ss", 32'({SS2, SS1}), 32'b10);
      tick();
      chk("ls1_ld_oneclk", 32'({LD2, LD1}), 0);
      en_tick(1'b0);
      chk("disp_ck_even", 32'(CK), 0);
      en_tick(1'b0);
      chk("disp_ck_odd", 32'(CK), 32'b1100);
      tick();
      chk("disp_ck_oneclk", 32'(CK), 0);
      en_tick(1'b1);
      chk("ls2_tms0", 32'(TMS0), 0);
      chk("ls2_ld", 32'({LD2, LD1}), 32'b01);
      chk("ls2_ss", 32'({SS2, SS1}), 32'b01);
      en_tick(1'b1);
      chk("ls3_tms0", 32'(TMS0), 1);
      chk("ls3_ld", 32'({LD2, LD1}), 32'b10);
      en_tick(1'b1);
      chk("ls4_tms0", 32'(TMS0), 0);
      tick();

      // strip 1: X=0x020, all opaque, no flip, render pair T
      SPR_REQ = 1'b1; SPR_X = 9'h020; SPR_OPQ = 16'hFFFF; SPR_FLIP = 1'b0;
      en_tick(1'b0);
      chk("s1_busy", 32'(BUSY), 1);
      tick();
      en_tick(1'b0);
      chk("s1_ld", 32'({LD2, LD1}), 32'b10);
      chk("s1_ldaddr", 32'(LD_ADDR), 32'h1010);
      chk("s1_swap", 32'(SWAP), 0);
      tick();
      chk("s1_ld_oneclk", 32'({LD2, LD1}), 0);
      for (int k = 0; k < 8; k++) begin
         en_tick(1'b0);
         chk("s1_pidx", 32'(PAIR_IDX), 32'(k));
         chk("s1_we", 32'(WE), 32'b1100);
         chk("s1_ck_during_we", 32'(CK[3:2]), 0);
         chk("s1_ack_early", 32'(SPR_ACK), 0);
         we_tl += int'(WE[2]);
         we_tr += int'(WE[3]);
         tick();
         chk("s1_we_oneclk", 32'(WE), 0);
         chk("s1_ck_after_we", 32'(CK[3:2]), 32'b11);
      end
      chk("s1_we_tl_count", 32'(we_tl), 8);
      chk("s1_we_tr_count", 32'(we_tr), 8);
      en_tick(1'b0);
      chk("s1_ack", 32'(SPR_ACK), 1);
      chk("s1_busy_done", 32'(BUSY), 0);
      tick();
      chk("s1_ack_oneclk", 32'(SPR_ACK), 0);
      SPR_REQ = 1'b0;

      // strip 2: X=0x021, single opaque pixel 0, flipped
      SPR_REQ = 1'b1; SPR_X = 9'h021; SPR_OPQ = 16'h0001; SPR_FLIP = 1'b1;
      en_tick(1'b0);
      tick();
      en_tick(1'b0);
      chk("s2_swap", 32'(SWAP), 1);
      chk("s2_ldaddr", 32'(LD_ADDR), 32'h1011);
      chk("s2_ld", 32'({LD2, LD1}), 32'b10);
      tick();
      for (int k = 0; k < 8; k++) begin
         en_tick(1'b0);
         chk("s2_pidx", 32'(PAIR_IDX), 32'(7 - k));
         chk("s2_we", 32'(WE), (k == 7) ? 32'b1000 : 32'b0000);
         tick();
      end
      en_tick(1'b0);
      chk("s2_ack", 32'(SPR_ACK), 1);
      tick();
      SPR_REQ = 1'b0;

      // strip 3: LINE_START arrives when WRITE k=3 is due
      SPR_REQ = 1'b1; SPR_X = 9'h040; SPR_OPQ = 16'hFFFF; SPR_FLIP = 1'b0;
      en_tick(1'b0);
      tick();
      en_tick(1'b0);
      tick();
      for (int k = 0; k < 3; k++) begin
         en_tick(1'b0);
         tick();
      end
      en_tick(1'b1);
      chk("ab_abort", 32'(ABORT), 1);
      chk("ab_no_ack", 32'(SPR_ACK), 0);
      chk("ab_busy", 32'(BUSY), 0);
      chk("ab_tms0", 32'(TMS0), 1);
      chk("ab_we", 32'(WE), 0);
      chk("ab_disp_ld", 32'({LD2, LD1}), 32'b10);
      tick();
      chk("ab_abort_oneclk", 32'(ABORT), 0);
      chk("ab_ck", 32'(CK), 0);
      SPR_REQ = 1'b0;
      en_tick(1'b0);
      chk("ab_no_late_ack", 32'(SPR_ACK), 0);
      chk("ab_still_idle", 32'(BUSY), 0);
      tick();

      // strip 4: request and LINE_START on the same enable
      SPR_REQ = 1'b1; SPR_X = 9'h002; SPR_OPQ = 16'h0003; SPR_FLIP = 1'b0;
      en_tick(1'b1);
      chk("sim_tms0", 32'(TMS0), 0);
      chk("sim_not_accepted", 32'(BUSY), 0);
      chk("sim_no_abort", 32'(ABORT), 0);
      tick();
      en_tick(1'b0);
      chk("sim_accepted", 32'(BUSY), 1);
      tick();
      en_tick(1'b0);
      chk("sim_ld", 32'({LD2, LD1}), 32'b10);
      chk("sim_ldaddr", 32'(LD_ADDR), 32'h0101);
      chk("sim_swap", 32'(SWAP), 0);
      tick();
      for (int k = 0; k < 8; k++) begin
         en_tick(1'b0);
         chk("sim_we", 32'(WE), (k == 0) ? 32'b1100 : 32'b0000);
         tick();
      end
      en_tick(1'b0);
      chk("sim_ack", 32'(SPR_ACK), 1);
      tick();
      SPR_REQ = 1'b0;

      // strip 5: nRST asserted during WRITE k=5
      en_tick(1'b1);
      chk("rs_tms0_pre", 32'(TMS0), 1);
      tick();
      SPR_REQ = 1'b1; SPR_X = 9'h010; SPR_OPQ = 16'hFFFF; SPR_FLIP = 1'b0;
      en_tick(1'b0);
      tick();
      en_tick(1'b0);
      chk("rs_ld_b", 32'({LD2, LD1}), 32'b01);
      chk("rs_ldaddr", 32'(LD_ADDR), 32'h0808);
      tick();
      for (int k = 0; k < 5; k++) begin
         en_tick(1'b0);
         tick();
      end
      en_tick(1'b0);
      chk("rs_we_k5", 32'(WE), 32'b0011);
      chk("rs_pidx_k5", 32'(PAIR_IDX), 5);
      #1 nRST = 1'b0;
      #1;
      chk("rs_async_we", 32'(WE), 0);
      chk("rs_async_tms0", 32'(TMS0), 0);
      chk("rs_async_busy", 32'(BUSY), 0);
      chk("rs_async_pidx", 32'(PAIR_IDX), 0);
      chk("rs_async_ack_abort", 32'({SPR_ACK, ABORT}), 0);
      @(negedge CLK);
      nRST = 1'b1;
      tick();
      chk("rs_post_tms0", 32'(TMS0), 0);
      chk("rs_post_ack_abort", 32'({SPR_ACK, ABORT}), 0);
      en_tick(1'b0);
      chk("rs_new_busy", 32'(BUSY), 1);
      tick();
      en_tick(1'b0);
      chk("rs_new_ld", 32'({LD2, LD1}), 32'b10);
      chk("rs_new_ldaddr", 32'(LD_ADDR), 32'h0808);
      tick();
      for (int k = 0; k < 8; k++) begin
         en_tick(1'b0);
         chk("rs_new_we", 32'(WE), 32'b1100);
         tick();
      end
      en_tick(1'b0);
      chk("rs_new_ack", 32'(SPR_ACK), 1);
      chk("rs_new_abort", 32'(ABORT), 0);
      tick();
      chk("rs_new_ack_oneclk", 32'(SPR_ACK), 0);
      SPR_REQ = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
